// File: rtl/vga_timing_controller_if.sv
// Bus between the VGA timing controller and the pixel renderer.
// The controller (master) takes the pixel strobe and run request and drives
// the raster position, the draw window and the sync/status outputs.
interface vga_timing_controller_if;
    logic        pix_en;
    logic        run;
    logic [10:0] x;
    logic [10:0] y;
    logic        candraw;
    logic        hsync_n;
    logic        vsync_n;
    logic        frame_start;
    logic        busy;

    modport master (
        input  pix_en, run,
        output x, y, candraw, hsync_n, vsync_n, frame_start, busy
    );

    modport slave (
        output pix_en, run,
        input  x, y, candraw, hsync_n, vsync_n, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing: x/y scan counters, draw window, sync generation and
// frame-boundary start/stop sequencing. The raster advances only on pix_en
// cycles. Syncs are delayed by SYNC_DELAY clk to line up with a registered
// RGB path downstream.
module vga_timing_controller #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input logic                     clk,
    input logic                     reset,
    vga_timing_controller_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    // Output values at the origin, used when a frame starts from IDLE.
    localparam logic ORIGIN_DRAW = (H_ACTIVE > 0) && (V_ACTIVE > 0);
    localparam logic ORIGIN_HS   = (H_ACTIVE + H_FRONT) != 0;
    localparam logic ORIGIN_VS   = (V_ACTIVE + V_FRONT) != 0;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t      state;
    logic [10:0] x;
    logic [10:0] y;
    logic        candraw;
    logic        hs_raw;
    logic        vs_raw;
    logic        frame_start;
    logic        busy;

    logic [10:0] x_next;
    logic [10:0] y_next;
    logic        frame_end;

    // Next raster position and end-of-frame detect.
    always_comb begin
        frame_end = (x == H_LAST) && (y == V_LAST);
        x_next    = (x == H_LAST) ? 11'd0 : x + 11'd1;
        y_next    = y;
        if (x == H_LAST) begin
            y_next = (y == V_LAST) ? 11'd0 : y + 11'd1;
        end
    end

    // Run/stop sequencing; counters, draw window, raw syncs and frame_start
    // are all updated together so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x           <= 11'd0;
            y           <= 11'd0;
            candraw     <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else if (!bus.pix_en) begin
            // Frozen raster, but frame_start must stay a single-clk pulse.
            frame_start <= 1'b0;
        end else if (state == IDLE) begin
            frame_start <= 1'b0;
            if (bus.run) begin
                state       <= RUN;
                x           <= 11'd0;
                y           <= 11'd0;
                candraw     <= ORIGIN_DRAW;
                hs_raw      <= ORIGIN_HS;
                vs_raw      <= ORIGIN_VS;
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end
        end else if (!bus.run && frame_end) begin
            // Wind-down reaches the frame wrap: park at the origin.
            state       <= IDLE;
            x           <= 11'd0;
            y           <= 11'd0;
            candraw     <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= bus.run ? RUN : STOPPING;
            x           <= x_next;
            y           <= y_next;
            candraw     <= (x_next < H_VIS) && (y_next < V_VIS);
            hs_raw      <= !((x_next >= HS_START) && (x_next < HS_END));
            vs_raw      <= !((y_next >= VS_START) && (y_next < VS_END));
            frame_start <= frame_end;
            busy        <= 1'b1;
        end
    end

    assign bus.x           = x;
    assign bus.y           = y;
    assign bus.candraw     = candraw;
    assign bus.frame_start = frame_start;
    assign bus.busy        = busy;

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign bus.hsync_n = hs_raw;
            assign bus.vsync_n = vs_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_dly;
            logic [SYNC_DELAY-1:0] vs_dly;

            // Sync delay line: shifts every clk regardless of pix_en.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hs_dly <= '1;
                    vs_dly <= '1;
                end else begin
                    hs_dly <= SYNC_DELAY'({hs_dly, hs_raw});
                    vs_dly <= SYNC_DELAY'({vs_dly, vs_raw});
                end
            end

            assign bus.hsync_n = hs_dly[SYNC_DELAY-1];
            assign bus.vsync_n = vs_dly[SYNC_DELAY-1];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller using a shrunken raster so whole frames fit
// in a short run. A linear-position reference model predicts every output.
module tb_vga_timing_controller;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int SD = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic [26:0] RST_VEC = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    vga_timing_controller_if bus ();

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_DELAY(SD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: scan position as a single index into the frame.
    int m_mode = 0;  // 0 idle, 1 scanning with run, 2 scanning while winding down
    int m_pos  = 0;
    bit m_fs   = 1'b0;
    bit hq [0:SD];
    bit vq [0:SD];

    function automatic bit raw_h(int mode, int pos);
        int px = pos % HT;
        return !(mode != 0 && px >= HA + HF && px < HA + HF + HS);
    endfunction

    function automatic bit raw_v(int mode, int pos);
        int py = pos / HT;
        return !(mode != 0 && py >= VA + VF && py < VA + VF + VS);
    endfunction

    always @(posedge clk) begin
        for (int i = SD; i > 0; i--) begin
            hq[i] = hq[i-1];
            vq[i] = vq[i-1];
        end
        if (reset) begin
            m_mode = 0;
            m_pos  = 0;
            for (int i = 0; i <= SD; i++) begin
                hq[i] = 1'b1;
                vq[i] = 1'b1;
            end
            m_fs = 1'b0;
        end else if (bus.pix_en) begin
            if (m_mode == 0) begin
                if (bus.run) m_mode = 1;
            end else if (!bus.run && m_pos == FRAME - 1) begin
                m_mode = 0;
                m_pos  = 0;
            end else begin
                m_mode = bus.run ? 1 : 2;
                m_pos  = (m_pos + 1) % FRAME;
            end
            // A step that lands on the origin while scanning is a frame start.
            m_fs = (m_mode != 0) && (m_pos == 0);
        end else begin
            m_fs = 1'b0;
        end
        hq[0] = raw_h(m_mode, m_pos);
        vq[0] = raw_v(m_mode, m_pos);
    end

    logic        e_cand;
    logic [26:0] exp_vec;
    logic [26:0] dut_vec;
    assign e_cand  = (m_mode != 0) && (m_pos % HT < HA) && (m_pos / HT < VA);
    assign exp_vec = {11'(m_pos % HT), 11'(m_pos / HT), e_cand, hq[SD], vq[SD], m_fs, m_mode != 0};
    assign dut_vec = {bus.x, bus.y, bus.candraw, bus.hsync_n, bus.vsync_n, bus.frame_start, bus.busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int wx, input int wy, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.x == 11'(wx) && bus.y == 11'(wy)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.run = 1'b1; bus.pix_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec !== RST_VEC) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h exp %h", i, dut_vec, RST_VEC);
            end
        end
        reset = 1'b0; bus.run = 1'b0;
        tick();
        checks++;
        if (dut_vec !== RST_VEC || exp_vec !== RST_VEC) begin
            errors++;
            $display("FAIL idle_no_run got %h exp %h", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_start_latency();
        bus.run = 1'b1;
        tick();
        checks++;
        if ({bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy} !== {22'd0, 3'b111}) begin
            errors++;
            $display("FAIL start_latency got x=%0d y=%0d cd=%b fs=%b busy=%b exp 0 0 1 1 1",
                     bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy);
        end
        tick();
        checks++;
        if (bus.x !== 11'd1 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL second_pixel got x=%0d fs=%b exp x=1 fs=0", bus.x, bus.frame_start);
        end
    endtask

    task automatic test_full_frame();
        int draw = 0, hlen = 0, vlen = 0, fs_gap = -1;
        bit hseen = 0, vseen = 0;
        bit hprev = bus.hsync_n;
        bit vprev = bus.vsync_n;
        bus.run = 1'b1; bus.pix_en = 1'b1;
        for (int c = 0; c < 2 * FRAME + 20; c++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL full_frame_model t=%0t got %h exp %h", $time, dut_vec, exp_vec);
            end
            if (c < FRAME) draw += int'(bus.candraw);
            if (!bus.hsync_n) begin
                if (hprev) begin
                    hseen = 1; hlen = 0;
                    checks++;
                    if (bus.x !== 11'((HA + HF + SD) % HT)) begin
                        errors++;
                        $display("FAIL hsync_start_x got %0d exp %0d", bus.x, (HA + HF + SD) % HT);
                    end
                end
                hlen++;
            end else if (!hprev && hseen) begin
                checks++;
                if (hlen != HS) begin
                    errors++;
                    $display("FAIL hsync_width got %0d exp %0d", hlen, HS);
                end
            end
            hprev = bus.hsync_n;
            if (!bus.vsync_n) begin
                if (vprev) begin
                    vseen = 1; vlen = 0;
                    checks++;
                    if (bus.y !== 11'(VA + VF) || bus.x !== 11'(SD)) begin
                        errors++;
                        $display("FAIL vsync_start got (%0d,%0d) exp (%0d,%0d)", bus.x, bus.y, SD, VA + VF);
                    end
                end
                vlen++;
            end else if (!vprev && vseen) begin
                checks++;
                if (vlen != VS * HT) begin
                    errors++;
                    $display("FAIL vsync_width got %0d exp %0d", vlen, VS * HT);
                end
            end
            vprev = bus.vsync_n;
            if (fs_gap >= 0) fs_gap++;
            if (bus.frame_start) begin
                if (fs_gap > 0) begin
                    checks++;
                    if (fs_gap != FRAME) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", fs_gap, FRAME);
                    end
                end
                fs_gap = 0;
            end
        end
        checks++;
        if (draw != HA * VA) begin
            errors++;
            $display("FAIL candraw_count got %0d exp %0d", draw, HA * VA);
        end
    endtask

    task automatic test_divided();
        int k = int'($urandom_range(2, 3));
        int lastfall = -1;
        bit hprev = bus.hsync_n;
        bit fprev = bus.frame_start;
        logic [10:0] xprev;
        for (int c = 0; c < 2 * FRAME * k + 10; c++) begin
            bus.pix_en = (c % k == 0);
            xprev = bus.x;
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL divided_model k=%0d t=%0t got %h exp %h", k, $time, dut_vec, exp_vec);
            end
            if (!bus.pix_en) begin
                checks++;
                if (bus.x !== xprev) begin
                    errors++;
                    $display("FAIL divided_hold got x=%0d exp %0d", bus.x, xprev);
                end
            end
            if (bus.frame_start) begin
                checks++;
                if (fprev) begin
                    errors++;
                    $display("FAIL fs_width got 2+ clk exp 1 clk");
                end
            end
            fprev = bus.frame_start;
            if (hprev && !bus.hsync_n) begin
                if (lastfall >= 0) begin
                    checks++;
                    if (c - lastfall != k * HT) begin
                        errors++;
                        $display("FAIL divided_line got %0d exp %0d", c - lastfall, k * HT);
                    end
                end
                lastfall = c;
            end
            hprev = bus.hsync_n;
        end
        bus.pix_en = 1'b1;
    endtask

    task automatic test_stop_mid();
        bit ok;
        int n = 0;
        bus.run = 1'b1; bus.pix_en = 1'b1;
        wait_pos(3, 4, 2 * FRAME + 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stop_reach got timeout exp (3,4)");
        end
        bus.run = 1'b0;
        while (bus.busy && n < FRAME + 5) begin
            tick();
            n++;
            checks++;
            if (dut_vec !== exp_vec || bus.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL stop_model t=%0t got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        checks++;
        if (n != FRAME - (4 * HT + 3)) begin
            errors++;
            $display("FAIL stop_length got %0d exp %0d", n, FRAME - (4 * HT + 3));
        end
        checks++;
        if ({bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy} !== 25'd0) begin
            errors++;
            $display("FAIL stop_idle got x=%0d y=%0d cd=%b fs=%b busy=%b exp all 0",
                     bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy);
        end
    endtask

    task automatic test_resume();
        bit ok;
        bit seen = 0;
        bus.run = 1'b1;
        tick();
        wait_pos(0, 2, 2 * FRAME, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL resume_reach got timeout exp (0,2)");
        end
        bus.run = 1'b0;
        for (int i = 0; i < 2 * FRAME && bus.y != 11'd7; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec || !bus.busy) begin
                errors++;
                $display("FAIL resume_stopping t=%0t got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        bus.run = 1'b1;
        for (int i = 0; i < FRAME && !seen; i++) begin
            tick();
            seen = bus.frame_start;
            checks++;
            if (dut_vec !== exp_vec || !bus.busy) begin
                errors++;
                $display("FAIL resume_run t=%0t got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        checks++;
        if (!seen || bus.x !== 11'd0 || bus.y !== 11'd0) begin
            errors++;
            $display("FAIL resume_wrap got fs=%b (%0d,%0d) exp fs=1 (0,0)", seen, bus.x, bus.y);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        bus.run = 1'b1; bus.pix_en = 1'b1;
        wait_pos(HT - 1, VT - 1, 2 * FRAME, ok);
        bus.run = 1'b0;
        tick();
        checks++;
        if (!ok || {bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy} !== 25'd0) begin
            errors++;
            $display("FAIL run_drop_last got ok=%b x=%0d y=%0d fs=%b busy=%b exp idle origin",
                     ok, bus.x, bus.y, bus.frame_start, bus.busy);
        end
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        tick();
        wait_pos(HT - 1, VT - 1, 2 * FRAME, ok);
        bus.run = 1'b1;
        tick();
        checks++;
        if (!ok || {bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy} !== {22'd0, 3'b111}) begin
            errors++;
            $display("FAIL run_rise_wrap got ok=%b x=%0d y=%0d cd=%b fs=%b busy=%b exp 0 0 1 1 1",
                     ok, bus.x, bus.y, bus.candraw, bus.frame_start, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bus.run = 1'b1; bus.pix_en = 1'b1;
        wait_pos(5, 3, 2 * FRAME, ok);
        reset = 1'b1;
        tick();
        checks++;
        if (!ok || dut_vec !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid got ok=%b %h exp %h", ok, dut_vec, RST_VEC);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.x, bus.y, bus.frame_start, bus.busy} !== {22'd0, 2'b11}) begin
            errors++;
            $display("FAIL restart got x=%0d y=%0d fs=%b busy=%b exp 0 0 1 1",
                     bus.x, bus.y, bus.frame_start, bus.busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            bus.pix_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) bus.run = ~bus.run;
            reset = ($urandom_range(0, 399) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_model t=%0t got %h exp %h", $time, dut_vec, exp_vec);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.pix_en = 1'b0;
        test_reset();
        test_start_latency();
        test_full_frame();
        test_divided();
        test_stop_mid();
        test_resume();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached without finishing");
        $fatal(1, "timeout");
    end
endmodule
